// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results queue in a small FIFO and drain in idle slots, with a starvation-forced hold.
module rf_wport_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_wen,
  input  logic [4:0]                   wb_waddr,
  input  logic [31:0]                  wb_wdata,
  output logic                         wb_hold,
  input  logic                         lu_valid,
  output logic                         lu_ready,
  input  logic [4:0]                   lu_waddr,
  input  logic [31:0]                  lu_wdata,
  output logic                         rf_wen,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [31:0]                  pend_mask,
  output logic                         proto_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;
  logic          perr_q;

  logic          fifo_empty, enq, grant_fifo, grant_wb;
  logic [PW-1:0] off;

  // Handshake and grant decisions
  always_comb begin
    fifo_empty = (count_q == '0);
    lu_ready   = ~rst & (count_q < CW'(DEPTH));
    enq        = lu_valid & lu_ready & (lu_waddr != 5'd0);
    grant_fifo = ~rst & ~fifo_empty & (hold_q | ~wb_wen);
    grant_wb   = ~rst & ~grant_fifo & ~hold_q & wb_wen;
  end

  // Register-file write mux
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (grant_fifo) begin
      rf_wen   = 1'b1;
      rf_waddr = addr_q[rd_ptr];
      rf_wdata = data_q[rd_ptr];
    end else if (grant_wb) begin
      rf_wen   = (wb_waddr != 5'd0);
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end
  end

  // Occupancy and starvation bookkeeping; hold fires the cycle after the counter saturates
  always_comb begin
    count_d = count_q;
    case ({enq, grant_fifo})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    starve_d = starve_q;
    if (fifo_empty || grant_fifo)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
    hold_d = (starve_d == SW'(STARVE_LIMIT));
  end

  // Pending-destination mask over occupied slots
  always_comb begin
    pend_mask = 32'd0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (CW'(off) < count_q)
        pend_mask[addr_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (enq)        wr_ptr <= wr_ptr + PW'(1);
      if (grant_fifo) rd_ptr <= rd_ptr + PW'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      perr_q   <= perr_q | (hold_q & wb_wen);
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= lu_waddr;
      data_q[wr_ptr] <= lu_wdata;
    end
  end

  assign wb_hold    = hold_q;
  assign fifo_count = count_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter (DEPTH=2, STARVE_LIMIT=8) with immediate-assertion checks.
module tb_rf_wport_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_hold;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;
  logic [31:0] pend_mask;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  rf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .wb_hold    (wb_hold),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fifo_count (fifo_count),
    .pend_mask  (pend_mask),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    rst = 1'b1; wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0;
    tick; tick;
    settle;
    chk("rst_lu_ready",  32'(lu_ready), 32'd0);
    chk("rst_count",     32'(fifo_count), 32'd0);
    chk("rst_pend",      pend_mask, 32'd0);
    chk("rst_hold",      32'(wb_hold), 32'd0);
    chk("rst_proto",     32'(proto_err), 32'd0);
    chk("rst_rf_wen",    32'(rf_wen), 32'd0);
    rst = 1'b0;
    tick;

    // Idle drain
    lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'h1234;
    settle;
    chk("idle_lu_ready", 32'(lu_ready), 32'd1);
    chk("idle_rf_wen0",  32'(rf_wen), 32'd0);
    chk("idle_pend0",    pend_mask, 32'd0);
    tick;
    lu_valid = 1'b0;
    settle;
    chk("idle_count1",   32'(fifo_count), 32'd1);
    chk("idle_pend5",    pend_mask, 32'h20);
    chk("idle_rf_wen",   32'(rf_wen), 32'd1);
    chk("idle_rf_addr",  32'(rf_waddr), 32'd5);
    chk("idle_rf_data",  rf_wdata, 32'h1234);
    tick;
    settle;
    chk("idle_count0",   32'(fifo_count), 32'd0);
    chk("idle_pend_clr", pend_mask, 32'd0);
    chk("idle_rf_off",   32'(rf_wen), 32'd0);
    chk("idle_rf_addr0", 32'(rf_waddr), 32'd0);

    // Priority: pipeline beats queued x7
    wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hAA;
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
    tick;
    lu_valid = 1'b0;
    settle;
    chk("prio_rf_addr",  32'(rf_waddr), 32'd3);
    chk("prio_rf_data",  rf_wdata, 32'hAA);
    chk("prio_count",    32'(fifo_count), 32'd1);
    chk("prio_pend7",    pend_mask, 32'h80);
    tick;
    wb_wen = 1'b0;
    settle;
    chk("prio_drain_en", 32'(rf_wen), 32'd1);
    chk("prio_drain_a",  32'(rf_waddr), 32'd7);
    chk("prio_drain_d",  rf_wdata, 32'h77);
    tick;
    settle;
    chk("prio_count0",   32'(fifo_count), 32'd0);

    // Starvation: 8 denied cycles, then a one-cycle hold
    wb_wen = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h44;
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    tick;
    lu_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle;
      chk($sformatf("starve_hold0_c%0d", k), 32'(wb_hold), 32'd0);
      chk($sformatf("starve_wb_c%0d", k),    32'(rf_waddr), 32'd4);
      tick;
    end
    wb_wen = 1'b0;
    settle;
    chk("starve_hold",    32'(wb_hold), 32'd1);
    chk("starve_rf_wen",  32'(rf_wen), 32'd1);
    chk("starve_rf_addr", 32'(rf_waddr), 32'd9);
    chk("starve_rf_data", rf_wdata, 32'h99);
    tick;
    wb_wen = 1'b1;
    settle;
    chk("starve_hold_off", 32'(wb_hold), 32'd0);
    chk("starve_count0",   32'(fifo_count), 32'd0);
    chk("starve_proto",    32'(proto_err), 32'd0);
    chk("starve_wb_back",  32'(rf_waddr), 32'd4);
    tick;

    // Full and pointer wrap, five rounds
    for (int r = 0; r < 5; r++) begin
      wb_wen = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h44;
      lu_valid = 1'b1; lu_waddr = 5'd1; lu_wdata = 32'h100 + 32'(r);
      tick;
      lu_waddr = 5'd2; lu_wdata = 32'h200 + 32'(r);
      settle;
      chk($sformatf("full_ready1_r%0d", r), 32'(lu_ready), 32'd1);
      tick;
      lu_valid = 1'b0;
      settle;
      chk($sformatf("full_ready0_r%0d", r), 32'(lu_ready), 32'd0);
      chk($sformatf("full_count_r%0d", r),  32'(fifo_count), 32'd2);
      chk($sformatf("full_pend_r%0d", r),   pend_mask, 32'h6);
      chk($sformatf("full_wb_r%0d", r),     32'(rf_waddr), 32'd4);
      tick;
      wb_wen = 1'b0;
      settle;
      chk($sformatf("wrap_a1_r%0d", r), 32'(rf_waddr), 32'd1);
      chk($sformatf("wrap_d1_r%0d", r), rf_wdata, 32'h100 + 32'(r));
      tick;
      settle;
      chk($sformatf("wrap_a2_r%0d", r), 32'(rf_waddr), 32'd2);
      chk($sformatf("wrap_d2_r%0d", r), rf_wdata, 32'h200 + 32'(r));
      tick;
      settle;
      chk($sformatf("wrap_empty_r%0d", r), 32'(fifo_count), 32'd0);
    end

    // x0 result is accepted and discarded
    lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hDEAD;
    settle;
    chk("x0_ready", 32'(lu_ready), 32'd1);
    tick;
    lu_valid = 1'b0;
    settle;
    chk("x0_count",  32'(fifo_count), 32'd0);
    chk("x0_rf_wen", 32'(rf_wen), 32'd0);

    // Protocol violation: wb_wen held high through the forced hold
    wb_wen = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h44;
    lu_valid = 1'b1; lu_waddr = 5'd6; lu_wdata = 32'h66;
    tick;
    lu_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle;
      chk($sformatf("perr_hold0_c%0d", k), 32'(wb_hold), 32'd0);
      tick;
    end
    settle;
    chk("perr_hold",    32'(wb_hold), 32'd1);
    chk("perr_rf_addr", 32'(rf_waddr), 32'd6);
    chk("perr_rf_data", rf_wdata, 32'h66);
    chk("perr_not_yet", 32'(proto_err), 32'd0);
    tick;
    settle;
    chk("perr_set",     32'(proto_err), 32'd1);
    chk("perr_count0",  32'(fifo_count), 32'd0);
    wb_wen = 1'b0;
    tick; tick; tick;
    settle;
    chk("perr_sticky",  32'(proto_err), 32'd1);

    // Reset with two entries queued
    wb_wen = 1'b1; wb_waddr = 5'd4;
    lu_valid = 1'b1; lu_waddr = 5'd10; lu_wdata = 32'hA0;
    tick;
    lu_waddr = 5'd11; lu_wdata = 32'hB0;
    tick;
    lu_valid = 1'b0;
    settle;
    chk("mid_count2", 32'(fifo_count), 32'd2);
    chk("mid_pend",   pend_mask, 32'h0C00);
    tick;
    rst = 1'b1; wb_wen = 1'b0;
    settle;
    chk("mid_rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("mid_rst_ready",  32'(lu_ready), 32'd0);
    tick;
    rst = 1'b0;
    settle;
    chk("mid_count0", 32'(fifo_count), 32'd0);
    chk("mid_pend0",  pend_mask, 32'd0);
    chk("mid_proto0", 32'(proto_err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_no_write_%0d", k), 32'(rf_wen), 32'd0);
      tick;
      settle;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
